// File: rtl/controlador_ataque.sv
// Attack-phase resolver for the 5x7 battleship matrix: latches the saved board,
// classifies confirmed shots and drives the attack display. Optional miss blink: PISCAR_ERRO_EN.
module controlador_ataque #(
  parameter int MAX_TIROS = 20,
  parameter int DIV_PISCA = 25_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       iniciar,
  input  logic [6:0] coluna1_jogo_salvo,
  input  logic [6:0] coluna2_jogo_salvo,
  input  logic [6:0] coluna3_jogo_salvo,
  input  logic [6:0] coluna4_jogo_salvo,
  input  logic [6:0] coluna5_jogo_salvo,
  input  logic       confirmar_ataque,
  input  logic [2:0] ataque_colunas,
  input  logic [2:0] ataque_linhas,
  output logic [6:0] coluna1_saida,
  output logic [6:0] coluna2_saida,
  output logic [6:0] coluna3_saida,
  output logic [6:0] coluna4_saida,
  output logic [6:0] coluna5_saida,
  output logic       acerto,
  output logic       erro,
  output logic       repetido,
  output logic       invalido,
  output logic [4:0] tiros,
  output logic [5:0] acertos,
  output logic       fim_de_jogo,
  output logic       vitoria
);

  localparam logic [2:0] OCIOSO   = 3'd0;
  localparam logic [2:0] CARREGAR = 3'd1;
  localparam logic [2:0] AGUARDAR = 3'd2;
  localparam logic [2:0] AVALIAR  = 3'd3;
  localparam logic [2:0] FIM      = 3'd4;
  localparam logic [4:0] MAX_T    = 5'(MAX_TIROS);

  logic [2:0]  estado;
  logic [34:0] tabuleiro, mapa_acerto, mapa_erro, tab_in, seg;
  logic [5:0]  navios, navios_in, idx, acertos_inc;
  logic [4:0]  tiros_inc;
  logic [2:0]  col_q, lin_q;
  logic        conf_q, pend, coord_ok, ja_tiro, e_navio, pisca_fase;

  assign tab_in = {coluna5_jogo_salvo, coluna4_jogo_salvo, coluna3_jogo_salvo,
                   coluna2_jogo_salvo, coluna1_jogo_salvo};

  always_comb begin
    navios_in = '0;
    for (int i = 0; i < 35; i++) navios_in = navios_in + {5'd0, ~tab_in[i]};
  end

  assign coord_ok    = (col_q <= 3'd4) && (lin_q <= 3'd6);
  assign idx         = coord_ok ? (6'(col_q) * 6'd7 + 6'(lin_q)) : 6'd0;
  assign ja_tiro     = mapa_acerto[idx] | mapa_erro[idx];
  assign e_navio     = ~tabuleiro[idx];
  assign tiros_inc   = tiros + 5'd1;
  assign acertos_inc = acertos + 6'd1;

`ifdef PISCAR_ERRO_EN
  logic [31:0] pisca_cnt;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pisca_cnt  <= '0;
      pisca_fase <= 1'b0;
    end else if (pisca_cnt == 32'(DIV_PISCA - 1)) begin
      pisca_cnt  <= '0;
      pisca_fase <= ~pisca_fase;
    end else begin
      pisca_cnt  <= pisca_cnt + 32'd1;
    end
  end
`else
  assign pisca_fase = 1'b0;
`endif

  // A confirm edge only arms 'pend'; AVALIAR runs the cycle after, so results land after E+2.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      estado      <= OCIOSO;
      tabuleiro   <= '1;
      mapa_acerto <= '0;
      mapa_erro   <= '0;
      navios      <= '0;
      tiros       <= '0;
      acertos     <= '0;
      vitoria     <= 1'b0;
      conf_q      <= 1'b0;
      pend        <= 1'b0;
      col_q       <= '0;
      lin_q       <= '0;
      acerto      <= 1'b0;
      erro        <= 1'b0;
      repetido    <= 1'b0;
      invalido    <= 1'b0;
    end else begin
      conf_q   <= confirmar_ataque;
      acerto   <= 1'b0;
      erro     <= 1'b0;
      repetido <= 1'b0;
      invalido <= 1'b0;
      case (estado)
        OCIOSO: if (iniciar) estado <= CARREGAR;
        CARREGAR: begin
          tabuleiro   <= tab_in;
          mapa_acerto <= '0;
          mapa_erro   <= '0;
          tiros       <= '0;
          acertos     <= '0;
          navios      <= navios_in;
          pend        <= 1'b0;
          if (navios_in == 6'd0) begin
            estado  <= FIM;
            vitoria <= 1'b1;
          end else begin
            estado  <= AGUARDAR;
            vitoria <= 1'b0;
          end
        end
        AGUARDAR: begin
          if (iniciar) begin
            estado <= CARREGAR;
            pend   <= 1'b0;
          end else if (pend) begin
            estado <= AVALIAR;
            pend   <= 1'b0;
          end else if (confirmar_ataque && !conf_q) begin
            col_q <= ataque_colunas;
            lin_q <= ataque_linhas;
            pend  <= 1'b1;
          end
        end
        AVALIAR: begin
          if (iniciar) begin
            estado <= CARREGAR;
          end else begin
            estado <= AGUARDAR;
            if (!coord_ok) begin
              invalido <= 1'b1;
            end else if (ja_tiro) begin
              repetido <= 1'b1;
            end else if (e_navio) begin
              mapa_acerto[idx] <= 1'b1;
              tiros            <= tiros_inc;
              acertos          <= acertos_inc;
              acerto           <= 1'b1;
              if (acertos_inc == navios) begin
                estado  <= FIM;
                vitoria <= 1'b1;
              end else if (tiros_inc == MAX_T) begin
                estado  <= FIM;
                vitoria <= 1'b0;
              end
            end else begin
              mapa_erro[idx] <= 1'b1;
              tiros          <= tiros_inc;
              erro           <= 1'b1;
              if (tiros_inc == MAX_T) begin
                estado  <= FIM;
                vitoria <= 1'b0;
              end
            end
          end
        end
        FIM: if (iniciar) estado <= CARREGAR;
        default: estado <= OCIOSO;
      endcase
    end
  end

  assign fim_de_jogo = (estado == FIM);

  // A lost game also reveals the ships that were never hit.
  always_comb begin
    seg = '1;
    for (int i = 0; i < 35; i++) begin
      if (mapa_acerto[i])
        seg[i] = 1'b0;
      else if (mapa_erro[i])
        seg[i] = ~pisca_fase;
      else if (fim_de_jogo && !vitoria && !tabuleiro[i])
        seg[i] = 1'b0;
    end
  end

  assign coluna1_saida = seg[6:0];
  assign coluna2_saida = seg[13:7];
  assign coluna3_saida = seg[20:14];
  assign coluna4_saida = seg[27:21];
  assign coluna5_saida = seg[34:28];

endmodule

// File: tb/tb_controlador_ataque.sv
// Self-checking bench for controlador_ataque: shot-level reference model, table vectors,
// directed corner sequences and randomized games.
module tb_controlador_ataque;
  localparam int MAXT = 3;
  localparam int DIV  = 4;

  logic        clk = 1'b0, rst_n = 1'b0, iniciar = 1'b0, confirmar = 1'b0;
  logic [2:0]  acol = '0, alin = '0;
  logic [34:0] brd = '1;
  logic [6:0]  s1, s2, s3, s4, s5;
  logic        acerto, erro, repetido, invalido, fim_de_jogo, vitoria;
  logic [4:0]  tiros;
  logic [5:0]  acertos;

  always #5 clk = ~clk;

  controlador_ataque #(.MAX_TIROS(MAXT), .DIV_PISCA(DIV)) dut (
    .clk(clk), .rst_n(rst_n), .iniciar(iniciar),
    .coluna1_jogo_salvo(brd[6:0]), .coluna2_jogo_salvo(brd[13:7]),
    .coluna3_jogo_salvo(brd[20:14]), .coluna4_jogo_salvo(brd[27:21]),
    .coluna5_jogo_salvo(brd[34:28]),
    .confirmar_ataque(confirmar), .ataque_colunas(acol), .ataque_linhas(alin),
    .coluna1_saida(s1), .coluna2_saida(s2), .coluna3_saida(s3),
    .coluna4_saida(s4), .coluna5_saida(s5),
    .acerto(acerto), .erro(erro), .repetido(repetido), .invalido(invalido),
    .tiros(tiros), .acertos(acertos), .fim_de_jogo(fim_de_jogo), .vitoria(vitoria)
  );

  // edges since the last reset edge, used to predict the blink phase
  int k;
  always @(posedge clk) if (!rst_n) k <= 0; else k <= k + 1;

  int n_pass = 0, n_chk = 0;

  // reference model: board (0 = ship), hit/miss sets, counters, game-over flags
  logic [34:0] mb, mh, mm;
  int mt, ma, mn;
  bit mfim, mvit;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic logic [34:0] disp_model();
    logic [34:0] d;
    bit ph;
`ifdef PISCAR_ERRO_EN
    ph = ((k / DIV) % 2) == 1;
`else
    ph = 1'b0;
`endif
    d = '1;
    for (int c = 0; c < 5; c++)
      for (int r = 0; r < 7; r++) begin
        int i;
        i = c * 7 + r;
        if (mh[i]) d[i] = 1'b0;
        else if (mm[i]) d[i] = !ph;
        else if (mfim && !mvit && !mb[i]) d[i] = 1'b0;
      end
    return d;
  endfunction

  function automatic logic [51:0] act_vec();
    return {acerto, erro, repetido, invalido, tiros, acertos, fim_de_jogo,
            fim_de_jogo & vitoria, s5, s4, s3, s2, s1};
  endfunction

  function automatic logic [51:0] exp_vec(input logic [3:0] p);
    return {p, 5'(mt), 6'(ma), mfim, mfim & mvit, disp_model()};
  endfunction

  task automatic chk(input string nm, input logic [3:0] p);
    check(nm, 64'(act_vec()), 64'(exp_vec(p)));
  endtask

  // pulse code {acerto, erro, repetido, invalido}
  task automatic model_shot(input int c, input int r, output logic [3:0] p);
    int i;
    p = 4'd0;
    if (mfim) return;
    if (c > 4 || r > 6) begin p = 4'd1; return; end
    i = c * 7 + r;
    if (mh[i] || mm[i]) begin p = 4'd2; return; end
    if (!mb[i]) begin mh[i] = 1'b1; mt++; ma++; p = 4'd8; end
    else begin mm[i] = 1'b1; mt++; p = 4'd4; end
    if (ma == mn) begin mfim = 1; mvit = 1; end
    else if (mt == MAXT) begin mfim = 1; mvit = 0; end
  endtask

  task automatic model_start(input logic [34:0] b);
    mb = b; mh = '0; mm = '0; mt = 0; ma = 0; mn = 0;
    for (int i = 0; i < 35; i++) if (!b[i]) mn++;
    mfim = (mn == 0); mvit = (mn == 0);
  endtask

  task automatic start_game(input logic [34:0] b);
    @(negedge clk); brd = b; iniciar = 1'b1;
    @(negedge clk); iniciar = 1'b0;
    model_start(b);
    @(negedge clk); chk("start", 4'd0);
  endtask

  task automatic shot(input int c, input int r, output logic [3:0] pa);
    logic [3:0] p;
    @(negedge clk); acol = 3'(c); alin = 3'(r); confirmar = 1'b1;
    @(negedge clk); chk("shot_e0", 4'd0);
    @(negedge clk); chk("shot_e1", 4'd0);
    model_shot(c, r, p);
    @(negedge clk); chk("shot_res", p);
    pa = {acerto, erro, repetido, invalido};
    confirmar = 1'b0;
    @(negedge clk); chk("shot_after", 4'd0);
  endtask

  typedef struct { int c; int r; logic [3:0] p; int t; int a; } vec_t;
  vec_t tbl[6];

  initial begin
    logic [34:0] b;
    logic [3:0]  pa, p;
    int npul;

    tbl[0] = '{0, 0, 4'd4, 1, 0};
    tbl[1] = '{0, 0, 4'd2, 1, 0};
    tbl[2] = '{5, 0, 4'd1, 1, 0};
    tbl[3] = '{0, 7, 4'd1, 1, 0};
    tbl[4] = '{1, 1, 4'd8, 2, 1};
    tbl[5] = '{1, 1, 4'd2, 2, 1};

    mb = '1; mh = '0; mm = '0; mt = 0; ma = 0; mn = 0; mfim = 0; mvit = 0;
    @(negedge clk); @(negedge clk);
    chk("reset", 4'd0);
    check("reset_vit", 64'(vitoria), 64'd0);
    rst_n = 1'b1;

    // single ship at column 2 row 3
    b = '1; b[2*7+3] = 1'b0;
    start_game(b);
    shot(2, 3, pa);
    check("t1_col3", 64'(s3), 64'(7'b1110111));
    check("t1_end", 64'({fim_de_jogo, vitoria, tiros, acertos}), 64'({1'b1, 1'b1, 5'd1, 6'd1}));

    // two-ship board, table vectors
    b = '1; b[1*7+1] = 1'b0; b[3*7+4] = 1'b0;
    start_game(b);
    for (int i = 0; i < 6; i++) begin
      shot(tbl[i].c, tbl[i].r, pa);
      check("tbl_pulse", 64'(pa), 64'(tbl[i].p));
      check("tbl_cnt", 64'({tiros, acertos}), 64'({5'(tbl[i].t), 6'(tbl[i].a)}));
    end

    // budget exhaustion with unreachable ships, then a confirm in FIM is ignored
    b = '1; b[4*7+6] = 1'b0; b[3*7+5] = 1'b0;
    start_game(b);
    shot(0, 0, pa); shot(0, 1, pa); shot(0, 2, pa);
    check("lose_end", 64'({fim_de_jogo, vitoria, tiros}), 64'({1'b1, 1'b0, 5'd3}));
    check("lose_reveal", 64'({s5, s4}), 64'({7'b0111111, 7'b1011111}));
    shot(1, 1, pa);
    check("fim_nopulse", 64'(pa), 64'd0);

    // confirm held high for 10 cycles with coordinates changing
    b = '1; b[1*7+1] = 1'b0; b[3*7+4] = 1'b0;
    start_game(b);
    npul = 0;
    @(negedge clk); acol = 3'd2; alin = 3'd2; confirmar = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 2) begin model_shot(2, 2, p); chk("hold", p); end
      else chk("hold", 4'd0);
      npul += int'(acerto) + int'(erro) + int'(repetido) + int'(invalido);
      acol = 3'($urandom_range(0, 4)); alin = 3'($urandom_range(0, 6));
    end
    check("hold_count", 64'(npul), 64'd1);
    confirmar = 1'b0;

    // iniciar together with a confirm edge
    @(negedge clk); iniciar = 1'b1; confirmar = 1'b1; acol = 3'd0; alin = 3'd0;
    @(negedge clk); iniciar = 1'b0;
    check("ini_p0", 64'({acerto, erro, repetido, invalido}), 64'd0);
    model_start(b);
    @(negedge clk); chk("ini_restart", 4'd0);
    @(negedge clk); chk("ini_p2", 4'd0);
    confirmar = 1'b0;
    shot(0, 0, pa);
    check("ini_shot", 64'({pa, tiros}), 64'({4'd4, 5'd1}));

    // miss cell display over several blink periods
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); chk("blink", 4'd0);
    end

    // reset mid-game
    shot(1, 1, pa);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk);
    mb = '1; mh = '0; mm = '0; mt = 0; ma = 0; mn = 0; mfim = 0; mvit = 0;
    chk("rst_mid", 4'd0);
    check("rst_mid_vit", 64'(vitoria), 64'd0);
    rst_n = 1'b1;

    // randomized games
    for (int g = 0; g < 14; g++) begin
      int nsh;
      b = '1;
      nsh = (g == 0) ? 0 : int'($urandom_range(1, 3));
      for (int j = 0; j < nsh; j++) b[$urandom_range(0, 34)] = 1'b0;
      start_game(b);
      for (int s = 0; s < 8; s++) begin
        int c, r;
        if ($urandom_range(0, 2) == 0) begin
          c = $urandom_range(0, 7); r = $urandom_range(0, 7);
        end else begin
          c = $urandom_range(0, 4); r = $urandom_range(0, 6);
          if ($urandom_range(0, 1) == 1)
            for (int q = 0; q < 35; q++)
              if (!b[q] && $urandom_range(0, 1) == 1) begin c = q / 7; r = q % 7; end
        end
        shot(c, r, pa);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
